// File: rtl/arf062b064e1r1w0cbbehsaa4acw_bist_addr_seq_pkg.sv
// Shared types for the BIST address sequencer of the 62-entry 1R1W register file.
package arf062b064e1r1w0cbbehsaa4acw_bist_addr_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_bist_addr_seq_if.sv
// Control/address bundle between the BIST controller (master) and the address sequencer (slave).
interface arf062b064e1r1w0cbbehsaa4acw_bist_addr_seq_if #(
  parameter int DEPTH  = 62,
  parameter int PASS_W = 4,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              start;
  logic              dir;
  logic              alt;
  logic [PASS_W-1:0] passes;
  logic              hold;
  logic              abort;
  logic              busy;
  logic              addr_vld;
  logic [ADDR_W-1:0] addr;
  logic [DEPTH-1:0]  wl_onehot;
  logic              last;
  logic              done;

  modport master (
    output start, dir, alt, passes, hold, abort,
    input  busy, addr_vld, addr, wl_onehot, last, done
  );

  modport slave (
    input  start, dir, alt, passes, hold, abort,
    output busy, addr_vld, addr, wl_onehot, last, done
  );
endinterface

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_bist_wl_dec.sv
// Binary-to-one-hot wordline decoder; all-zero when disabled or when the index is out of range.
module arf062b064e1r1w0cbbehsaa4acw_bist_wl_dec #(
  parameter int IN_W      = 6,
  parameter int OUT_WIDTH = 62
) (
  input  logic                 en_i,
  input  logic [IN_W-1:0]      bin_i,
  output logic [OUT_WIDTH-1:0] onehot_o
);

  logic in_range_s;

  // Range gate plus one comparator per existing wordline.
  always_comb begin
    onehot_o   = {OUT_WIDTH{1'b0}};
    in_range_s = (int'(bin_i) < OUT_WIDTH);
    for (int i = 0; i < OUT_WIDTH; i++) begin
      onehot_o[i] = en_i && in_range_s && (bin_i == IN_W'(i));
    end
  end

endmodule

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_bist_addr_seq.sv
// BIST address sequencer: multi-pass ascending/descending word sweep with hold, abort and
// optional per-pass direction alternation; all outputs registered.
module arf062b064e1r1w0cbbehsaa4acw_bist_addr_seq
  import arf062b064e1r1w0cbbehsaa4acw_bist_addr_seq_pkg::*;
#(
  parameter int DEPTH  = 62,
  parameter int PASS_W = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst_n,
  arf062b064e1r1w0cbbehsaa4acw_bist_addr_seq_if.slave bus
);

  localparam logic [1:0]        IDLE      = ST_IDLE;
  localparam logic [1:0]        RUN       = ST_RUN;
  localparam logic [1:0]        DONE      = ST_DONE;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
  localparam logic [PASS_W-1:0] PASS_ZERO = {PASS_W{1'b0}};
  localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1'b1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic              alt_q, alt_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              vld_q, busy_q, last_q, done_q;
  logic [DEPTH-1:0]  wl_q, wl_d;
  logic              at_term_s, run_d_s, last_d_s;

  assign at_term_s = dir_q ? (addr_q == ADDR_ZERO) : (addr_q == ADDR_LAST);

  // Sequencer next-state: abort first, then the IDLE/RUN/DONE transitions.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dir_d   = dir_q;
    alt_d   = alt_q;
    pass_d  = pass_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = RUN;
            dir_d   = bus.dir;
            alt_d   = bus.alt;
            pass_d  = (bus.passes == PASS_ZERO) ? PASS_ZERO : (bus.passes - PASS_ONE);
            addr_d  = bus.dir ? ADDR_LAST : ADDR_ZERO;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (bus.hold) begin
            state_d = RUN;
          end else if (!at_term_s) begin
            addr_d = dir_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          end else if (pass_q != PASS_ZERO) begin
            pass_d = pass_q - PASS_ONE;
            // With alternation the terminal word doubles as the first word of the reversed pass.
            if (alt_q) begin
              dir_d = ~dir_q;
            end else begin
              addr_d = dir_q ? ADDR_LAST : ADDR_ZERO;
            end
          end else begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign run_d_s  = (state_d == RUN);
  assign last_d_s = run_d_s && (pass_d == PASS_ZERO) &&
                    (addr_d == (dir_d ? ADDR_ZERO : ADDR_LAST));

  arf062b064e1r1w0cbbehsaa4acw_bist_wl_dec #(
    .IN_W      (ADDR_W),
    .OUT_WIDTH (DEPTH)
  ) u_wl_dec (
    .en_i     (run_d_s),
    .bin_i    (addr_d),
    .onehot_o (wl_d)
  );

  // State and output registers; outputs are derived from next-state so they align with addr_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= ADDR_ZERO;
      dir_q   <= 1'b0;
      alt_q   <= 1'b0;
      pass_q  <= PASS_ZERO;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      wl_q    <= {DEPTH{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      alt_q   <= alt_d;
      pass_q  <= pass_d;
      vld_q   <= run_d_s;
      busy_q  <= (state_d != IDLE);
      last_q  <= last_d_s;
      done_q  <= (state_d == DONE);
      wl_q    <= wl_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.addr_vld  = vld_q;
  assign bus.addr      = addr_q;
  assign bus.wl_onehot = wl_q;
  assign bus.last      = last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_arf062b064e1r1w0cbbehsaa4acw_bist_addr_seq.sv
// Self-checking bench: directed scenarios plus random stimulus against a queue-based sweep model.
module tb_arf062b064e1r1w0cbbehsaa4acw_bist_addr_seq;

  localparam int DEPTH  = 62;
  localparam int PASS_W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  arf062b064e1r1w0cbbehsaa4acw_bist_addr_seq_if #(.DEPTH(DEPTH), .PASS_W(PASS_W)) io ();

  arf062b064e1r1w0cbbehsaa4acw_bist_addr_seq #(.DEPTH(DEPTH), .PASS_W(PASS_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 run, 2 done; q holds the remaining addresses, q[0] is the one on the bus.
  int m_mode;
  int q[$];

  initial begin
    m_mode = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || io.abort) begin
        m_mode = 0;
        q.delete();
      end else begin
        case (m_mode)
          0: if (io.start) begin
            int p;
            p = (io.passes == 0) ? 1 : int'(io.passes);
            for (int k = 0; k < p; k++) begin
              bit d;
              d = io.alt ? (io.dir ^ k[0]) : io.dir;
              for (int a = 0; a < DEPTH; a++) q.push_back(d ? DEPTH - 1 - a : a);
            end
            m_mode = 1;
          end
          1: if (!io.hold) begin
            void'(q.pop_front());
            if (q.size() == 0) m_mode = 2;
          end
          default: m_mode = 0;
        endcase
      end
    end
  end

  int vld_cnt, done_cnt, cnt30, log_n;
  logic [7:0] log_a [0:2047];

  // Compare process plus monitor counters used by the directed literal checks.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_busy", 64'(io.busy), 64'd0);
        chk("rst_vld", 64'(io.addr_vld), 64'd0);
        chk("rst_wl", 64'(io.wl_onehot), 64'd0);
        chk("rst_done", 64'(io.done), 64'd0);
      end else begin
        chk("busy", 64'(io.busy), 64'(m_mode != 0));
        chk("addr_vld", 64'(io.addr_vld), 64'(m_mode == 1));
        chk("done", 64'(io.done), 64'(m_mode == 2));
        if (m_mode == 1) begin
          chk("addr", 64'(io.addr), 64'(q[0]));
          chk("wl_onehot", 64'(io.wl_onehot), 64'd1 << q[0]);
          chk("last", 64'(io.last), 64'(q.size() == 1));
        end else begin
          chk("wl_idle", 64'(io.wl_onehot), 64'd0);
          chk("last_idle", 64'(io.last), 64'd0);
        end
      end
      if (io.addr_vld) begin
        vld_cnt++;
        if (log_n < 2048) log_a[log_n] = 8'(io.addr);
        log_n++;
        if (io.addr == 6'd30) cnt30++;
      end
      if (io.done) done_cnt++;
    end
  end

  task automatic clr_mon();
    vld_cnt = 0; done_cnt = 0; cnt30 = 0; log_n = 0;
  endtask

  task automatic start_seq(input bit d, input bit a, input int p);
    clr_mon();
    @(posedge clk); #1;
    io.start = 1'b1; io.dir = d; io.alt = a; io.passes = PASS_W'(p);
    @(posedge clk); #1;
    io.start = 1'b0; io.dir = 1'($urandom); io.alt = 1'($urandom); io.passes = PASS_W'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
    else chk("busy_after_done", 64'(io.busy), 64'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    io.start = 1'b0; io.dir = 1'b0; io.alt = 1'b0; io.passes = '0; io.hold = 1'b0; io.abort = 1'b0;
    clr_mon();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_addr", 64'(io.addr), 64'd0);
    chk("reset_last", 64'(io.last), 64'd0);

    // Single ascending pass.
    start_seq(1'b0, 1'b0, 1);
    chk("t1_first_vld", 64'(io.addr_vld), 64'd1);
    chk("t1_first_addr", 64'(io.addr), 64'd0);
    wait_done(1000);
    chk("t1_vld_cnt", 64'(vld_cnt), 64'd62);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_log61", 64'(log_a[61]), 64'd61);

    // Descending start, alternating, two passes: terminal word 0 appears twice.
    start_seq(1'b1, 1'b1, 2);
    chk("t2_first_addr", 64'(io.addr), 64'd61);
    wait_done(1000);
    chk("t2_vld_cnt", 64'(vld_cnt), 64'd124);
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);
    chk("t2_log61", 64'(log_a[61]), 64'd0);
    chk("t2_log62", 64'(log_a[62]), 64'd0);
    chk("t2_log63", 64'(log_a[63]), 64'd1);
    chk("t2_log123", 64'(log_a[123]), 64'd61);

    // passes=0 behaves as one pass.
    start_seq(1'b0, 1'b0, 0);
    wait_done(1000);
    chk("t3_vld_cnt", 64'(vld_cnt), 64'd62);

    // Hold for 3 cycles at address 30.
    start_seq(1'b0, 1'b0, 1);
    repeat (30) @(posedge clk);
    #1 io.hold = 1'b1;
    repeat (3) @(posedge clk);
    #1 io.hold = 1'b0;
    wait_done(1000);
    chk("t4_vld_cnt", 64'(vld_cnt), 64'd65);
    chk("t4_addr30_cycles", 64'(cnt30), 64'd4);

    // Abort at address 17, then restart.
    start_seq(1'b0, 1'b0, 1);
    repeat (17) @(posedge clk);
    #1 io.abort = 1'b1;
    @(posedge clk); #1 io.abort = 1'b0;
    chk("t5_vld_after_abort", 64'(io.addr_vld), 64'd0);
    chk("t5_done_after_abort", 64'(io.done), 64'd0);
    repeat (5) @(posedge clk);
    #2;
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    chk("t5_vld_cnt", 64'(vld_cnt), 64'd18);
    start_seq(1'b0, 1'b0, 3);
    chk("t5_restart_addr", 64'(io.addr), 64'd0);
    chk("t5_restart_vld", 64'(io.addr_vld), 64'd1);
    wait_done(2000);
    chk("t5_vld_cnt3", 64'(vld_cnt), 64'd186);

    // Asynchronous reset mid-sweep.
    start_seq(1'b0, 1'b0, 1);
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'(io.busy), 64'd0);
    chk("t6_vld", 64'(io.addr_vld), 64'd0);
    chk("t6_addr", 64'(io.addr), 64'd0);
    chk("t6_wl", 64'(io.wl_onehot), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("t6_no_done", 64'(done_cnt), 64'd0);

    // Start while busy is ignored.
    start_seq(1'b0, 1'b0, 1);
    repeat (10) @(posedge clk);
    #1 io.start = 1'b1; io.dir = 1'b1;
    @(posedge clk); #1 io.start = 1'b0;
    wait_done(1000);
    chk("t7_vld_cnt", 64'(vld_cnt), 64'd62);
    chk("t7_log11", 64'(log_a[11]), 64'd11);

    // Random stimulus; the compare process checks every cycle against the model.
    repeat (6000) begin
      @(posedge clk); #1;
      io.start  = ($urandom_range(0, 15) == 0);
      io.dir    = 1'($urandom);
      io.alt    = 1'($urandom);
      io.passes = ($urandom_range(0, 7) == 0) ? PASS_W'($urandom) : PASS_W'($urandom_range(0, 3));
      io.hold   = ($urandom_range(0, 5) == 0);
      io.abort  = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    io.start = 1'b0; io.hold = 1'b0; io.abort = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
